// File: rtl/onplay_sequencer.sv
// onplay_sequencer
//   Per-frame scheduler for the GAME_PLAYING datapath. Each accepted frame tick
//   runs MOVE -> COLLISION -> CALCVALUE -> CHECKING. Each stage is started with a
//   one-cycle pulse, and the sequencer waits for that stage's done. It also keeps
//   the frame/phase counters, raises the enemy-shoot strobe, and records
//   overruns and stage timeouts.
//
// Ports
//   i_Clk, i_Rst          clock, asynchronous active-low reset
//   i_Enable              game is in GAME_PLAYING; low aborts and clears
//   i_Pause               blocks new frame starts only
//   i_FrameTick           end-of-visible-frame pulse
//   i_*Done               stage completion from the datapath units
//   o_*Start              one-cycle start pulse per stage
//   o_State               0 WAITING, 1 MOVE, 2 COLLISION, 3 CALCVALUE, 4 CHECKING
//   o_Phase               current phase, saturates at NUM_PHASES-1
//   o_EnemyShoot          one-cycle pulse when the frame counter wraps
//   o_Busy                o_State != WAITING
//   o_Overrun, o_Timeout  sticky error flags, cleared by i_Enable low
module onplay_sequencer #(
  parameter int unsigned MAX_PHASE_CNT = 100,
  parameter int unsigned NUM_PHASES    = 4,
  parameter int unsigned TIMEOUT_CYC   = 1023
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       i_Pause,
  input  logic       i_FrameTick,
  input  logic       i_MoveDone,
  input  logic       i_CollDone,
  input  logic       i_CalcDone,
  input  logic       i_CheckDone,
  output logic       o_MoveStart,
  output logic       o_CollStart,
  output logic       o_CalcStart,
  output logic       o_CheckStart,
  output logic [2:0] o_State,
  output logic [1:0] o_Phase,
  output logic       o_EnemyShoot,
  output logic       o_Busy,
  output logic       o_Overrun,
  output logic       o_Timeout
);

  localparam int unsigned FRAME_W = (MAX_PHASE_CNT > 1) ? $clog2(MAX_PHASE_CNT) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MAX_PHASE_CNT - 1);
  localparam logic [9:0]         STAGE_LAST = 10'(TIMEOUT_CYC - 1);
  localparam logic [1:0]         PHASE_LAST = 2'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    WAITING   = 3'd0,
    MOVE      = 3'd1,
    COLLISION = 3'd2,
    CALCVALUE = 3'd3,
    CHECKING  = 3'd4
  } state_t;

  state_t               state, stateNext;
  logic [9:0]           stageCnt, stageCntNext;
  logic [FRAME_W-1:0]   frameCnt, frameCntNext;
  logic [1:0]           phaseNext;
  logic                 moveStartNext, collStartNext, calcStartNext, checkStartNext;
  logic                 shootNext, overrunNext, timeoutNext;
  logic                 doneSel, doneOk, stageExpired;

  assign o_State = state;

  always_comb begin
    stateNext      = state;
    stageCntNext   = stageCnt;
    frameCntNext   = frameCnt;
    phaseNext      = o_Phase;
    moveStartNext  = 1'b0;
    collStartNext  = 1'b0;
    calcStartNext  = 1'b0;
    checkStartNext = 1'b0;
    shootNext      = 1'b0;
    overrunNext    = o_Overrun;
    timeoutNext    = o_Timeout;

    case (state)
      MOVE:      doneSel = i_MoveDone;
      COLLISION: doneSel = i_CollDone;
      CALCVALUE: doneSel = i_CalcDone;
      CHECKING:  doneSel = i_CheckDone;
      default:   doneSel = 1'b0;
    endcase
    // stageCnt is 0 only in the start-pulse cycle, so a done there is ignored.
    doneOk       = doneSel && (stageCnt != '0);
    // stageCnt+1 cycles have elapsed in the stage at this edge.
    stageExpired = (stageCnt == STAGE_LAST);

    if (!i_Enable) begin
      stateNext    = WAITING;
      stageCntNext = '0;
      frameCntNext = '0;
      phaseNext    = '0;
      overrunNext  = 1'b0;
      timeoutNext  = 1'b0;
    end else if (state == WAITING) begin
      stageCntNext = '0;
      if (i_FrameTick && !i_Pause) begin
        stateNext     = MOVE;
        moveStartNext = 1'b1;
      end
    end else begin
      // Busy covers the CHECKING->WAITING cycle too, so a tick there is dropped.
      if (i_FrameTick) overrunNext = 1'b1;
      if (doneOk || stageExpired) begin
        stageCntNext = '0;
        if (!doneOk) timeoutNext = 1'b1;
        case (state)
          MOVE: begin
            stateNext     = COLLISION;
            collStartNext = 1'b1;
          end
          COLLISION: begin
            stateNext     = CALCVALUE;
            calcStartNext = 1'b1;
          end
          CALCVALUE: begin
            stateNext      = CHECKING;
            checkStartNext = 1'b1;
          end
          default: begin
            stateNext = WAITING;
            if (frameCnt == FRAME_LAST) begin
              frameCntNext = '0;
              shootNext    = 1'b1;
              if (o_Phase != PHASE_LAST) phaseNext = o_Phase + 2'd1;
            end else begin
              frameCntNext = frameCnt + 1'b1;
            end
          end
        endcase
      end else begin
        stageCntNext = stageCnt + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state        <= WAITING;
      stageCnt     <= '0;
      frameCnt     <= '0;
      o_Phase      <= '0;
      o_MoveStart  <= 1'b0;
      o_CollStart  <= 1'b0;
      o_CalcStart  <= 1'b0;
      o_CheckStart <= 1'b0;
      o_EnemyShoot <= 1'b0;
      o_Busy       <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Timeout    <= 1'b0;
    end else begin
      state        <= stateNext;
      stageCnt     <= stageCntNext;
      frameCnt     <= frameCntNext;
      o_Phase      <= phaseNext;
      o_MoveStart  <= moveStartNext;
      o_CollStart  <= collStartNext;
      o_CalcStart  <= calcStartNext;
      o_CheckStart <= checkStartNext;
      o_EnemyShoot <= shootNext;
      o_Busy       <= (stateNext != WAITING);
      o_Overrun    <= overrunNext;
      o_Timeout    <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_onplay_sequencer.sv
// Testbench for onplay_sequencer: directed scenario tasks followed by random
// stimulus, all checked against a stage/age reference model kept in the bench.
module tb_onplay_sequencer;

  localparam int MAXP = 4;
  localparam int NPH  = 4;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rstN, en, pause, tick;
  logic moveDone, collDone, calcDone, checkDone;
  logic moveStart, collStart, calcStart, checkStart;
  logic [2:0] state;
  logic [1:0] phase;
  logic shoot, busy, overrun, timeout;

  onplay_sequencer #(
    .MAX_PHASE_CNT(MAXP),
    .NUM_PHASES   (NPH),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rstN),
    .i_Enable    (en),
    .i_Pause     (pause),
    .i_FrameTick (tick),
    .i_MoveDone  (moveDone),
    .i_CollDone  (collDone),
    .i_CalcDone  (calcDone),
    .i_CheckDone (checkDone),
    .o_MoveStart (moveStart),
    .o_CollStart (collStart),
    .o_CalcStart (calcStart),
    .o_CheckStart(checkStart),
    .o_State     (state),
    .o_Phase     (phase),
    .o_EnemyShoot(shoot),
    .o_Busy      (busy),
    .o_Overrun   (overrun),
    .o_Timeout   (timeout)
  );

  always #5 clk = ~clk;

  wire [12:0] outs = {state, phase, moveStart, collStart, calcStart, checkStart,
                      shoot, busy, overrun, timeout};

  int vecs = 0;
  int errs = 0;

  // Reference model: stage 0 = waiting, 1..4 = MOVE..CHECKING; age = cycles
  // already spent in the stage; frames counts completed frames in the phase.
  int mStage, mAge, mFrames, mPhase;
  bit mOver, mTo, mShoot;

  function automatic bit stageDone(int s);
    case (s)
      1:       return moveDone;
      2:       return collDone;
      3:       return calcDone;
      default: return checkDone;
    endcase
  endfunction

  task automatic model_clear();
    mStage = 0; mAge = 0; mFrames = 0; mPhase = 0;
    mOver = 0; mTo = 0; mShoot = 0;
  endtask

  task automatic model_step();
    bit hit;
    if (!en) begin
      model_clear();
    end else begin
      mShoot = 0;
      if (mStage == 0) begin
        if (tick && !pause) begin mStage = 1; mAge = 0; end
      end else begin
        if (tick) mOver = 1;
        hit = (mAge >= 1) && stageDone(mStage);
        if (hit || (mAge + 1 >= TO)) begin
          if (!hit) mTo = 1;
          mAge = 0;
          if (mStage == 4) begin
            mStage = 0;
            mFrames++;
            if (mFrames == MAXP) begin
              mFrames = 0;
              mShoot = 1;
              if (mPhase < NPH - 1) mPhase++;
            end
          end else begin
            mStage++;
          end
        end else begin
          mAge++;
        end
      end
    end
  endtask

  function automatic logic [12:0] mOuts();
    logic [3:0] st;
    st = (mStage != 0 && mAge == 0) ? 4'(4'b1000 >> (mStage - 1)) : 4'b0000;
    return {3'(mStage), 2'(mPhase), st, mShoot, (mStage != 0), mOver, mTo};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_dones(input logic m, input logic c, input logic k, input logic x);
    moveDone = m; collDone = c; calcDone = k; checkDone = x;
  endtask

  task automatic test_reset();
    rstN = 1'b0; en = 1'b0; pause = 1'b0; tick = 1'b0;
    set_dones(0, 0, 0, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (outs !== 13'd0) begin errs++; $display("FAIL reset_outs: got %h want 0", outs); end
    rstN = 1'b1;
    cyc();
    vecs++;
    if (outs !== 13'd0) begin errs++; $display("FAIL post_reset_outs: got %h want 0", outs); end
    // Disabled: ticks are ignored.
    for (int i = 0; i < 8; i++) begin
      tick = (i % 2 == 0);
      cyc();
      vecs++;
      if (state !== 3'd0 || moveStart !== 1'b0) begin
        errs++; $display("FAIL idle_disabled i=%0d: got state %0d start %b want 0 0", i, state, moveStart);
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_normal_frame();
    logic [2:0] expState;
    logic [3:0] expStarts;
    en = 1'b1; pause = 1'b0;
    cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    // n = edges since the tick was sampled; each done comes 3 cycles after its start.
    for (int n = 0; n <= 16; n++) begin
      expState  = (n < 16) ? 3'(n / 4 + 1) : 3'd0;
      expStarts = (n < 16 && n % 4 == 0) ? 4'(4'b1000 >> (n / 4)) : 4'b0000;
      vecs++;
      if (state !== expState) begin
        errs++; $display("FAIL normal_state n=%0d: got %0d want %0d", n, state, expState);
      end
      vecs++;
      if ({moveStart, collStart, calcStart, checkStart} !== expStarts) begin
        errs++; $display("FAIL normal_starts n=%0d: got %b want %b", n,
                         {moveStart, collStart, calcStart, checkStart}, expStarts);
      end
      vecs++;
      if (busy !== (n < 16)) begin
        errs++; $display("FAIL normal_busy n=%0d: got %b want %b", n, busy, (n < 16));
      end
      set_dones(n == 3, n == 7, n == 11, n == 15);
      if (n < 16) cyc();
    end
    set_dones(0, 0, 0, 0);
  endtask

  task automatic test_phase_wrap();
    int cnt;
    int expPhase;
    en = 1'b0; cyc(); en = 1'b1;
    set_dones(1, 1, 1, 1);
    for (int f = 1; f <= 17; f++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      vecs++;
      if (moveStart !== 1'b1 || shoot !== 1'b0) begin
        errs++; $display("FAIL wrap_start f=%0d: got start %b shoot %b want 1 0", f, moveStart, shoot);
      end
      cnt = 0;
      while (state !== 3'd0 && cnt < 20) begin cyc(); cnt++; end
      vecs++;
      if (cnt != 8) begin errs++; $display("FAIL wrap_frame_len f=%0d: got %0d want 8", f, cnt); end
      vecs++;
      if (shoot !== (f % 4 == 0)) begin
        errs++; $display("FAIL wrap_shoot f=%0d: got %b want %b", f, shoot, (f % 4 == 0));
      end
      expPhase = (f / 4 > NPH - 1) ? NPH - 1 : f / 4;
      vecs++;
      if (phase !== 2'(expPhase)) begin
        errs++; $display("FAIL wrap_phase f=%0d: got %0d want %0d", f, phase, expPhase);
      end
    end
  endtask

  task automatic test_abort();
    set_dones(1, 1, 0, 0);
    tick = 1'b1; cyc(); tick = 1'b0;
    repeat (5) cyc();
    vecs++;
    if (state !== 3'd3 || phase !== 2'd3) begin
      errs++; $display("FAIL abort_pre: got state %0d phase %0d want 3 3", state, phase);
    end
    en = 1'b0;
    cyc();
    vecs++;
    if (outs !== 13'd0) begin errs++; $display("FAIL abort_outs: got %h want 0", outs); end
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++;
      if (outs !== 13'd0) begin errs++; $display("FAIL abort_hold i=%0d: got %h want 0", i, outs); end
    end
    tick = 1'b0;
  endtask

  task automatic test_overrun();
    int cnt;
    en = 1'b1;
    set_dones(1, 1, 1, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    vecs++;
    if (state !== 3'd2 || overrun !== 1'b0) begin
      errs++; $display("FAIL overrun_pre: got state %0d ovr %b want 2 0", state, overrun);
    end
    tick = 1'b1; cyc(); tick = 1'b0;
    vecs++;
    if (overrun !== 1'b1 || state !== 3'd2) begin
      errs++; $display("FAIL overrun_set: got ovr %b state %0d want 1 2", overrun, state);
    end
    cnt = 3;
    while (state !== 3'd0 && cnt < 30) begin cyc(); cnt++; end
    vecs++;
    if (cnt != 8) begin errs++; $display("FAIL overrun_frame_len: got %0d want 8", cnt); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++;
      if (state !== 3'd0 || moveStart !== 1'b0 || overrun !== 1'b1) begin
        errs++; $display("FAIL overrun_no_extra i=%0d: got state %0d start %b ovr %b want 0 0 1",
                         i, state, moveStart, overrun);
      end
    end
    // Only one frame was counted, so the wrap comes at the 4th frame overall.
    for (int f = 2; f <= 4; f++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      cnt = 0;
      while (state !== 3'd0 && cnt < 20) begin cyc(); cnt++; end
      vecs++;
      if (shoot !== (f == 4)) begin
        errs++; $display("FAIL overrun_count f=%0d: got shoot %b want %b", f, shoot, (f == 4));
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    en = 1'b0; cyc(); en = 1'b1;
    vecs++;
    if (overrun !== 1'b0 || timeout !== 1'b0) begin
      errs++; $display("FAIL flags_cleared: got ovr %b to %b want 0 0", overrun, timeout);
    end
    set_dones(1, 0, 1, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    vecs++;
    if (state !== 3'd2 || collStart !== 1'b1) begin
      errs++; $display("FAIL timeout_entry: got state %0d start %b want 2 1", state, collStart);
    end
    for (int n = 3; n <= 11; n++) begin
      cyc();
      vecs++;
      if (state !== 3'd2 || timeout !== 1'b0 || calcStart !== 1'b0) begin
        errs++; $display("FAIL timeout_wait n=%0d: got state %0d to %b calc %b want 2 0 0",
                         n, state, timeout, calcStart);
      end
    end
    cyc();
    vecs++;
    if (state !== 3'd3 || timeout !== 1'b1 || calcStart !== 1'b1) begin
      errs++; $display("FAIL timeout_fire: got state %0d to %b calc %b want 3 1 1", state, timeout, calcStart);
    end
    cnt = 0;
    while (state !== 3'd0 && cnt < 30) begin cyc(); cnt++; end
    vecs++;
    if (state !== 3'd0 || timeout !== 1'b1) begin
      errs++; $display("FAIL timeout_sticky: got state %0d to %b want 0 1", state, timeout);
    end
  endtask

  task automatic test_pause();
    int cnt;
    en = 1'b1; pause = 1'b1;
    set_dones(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cyc();
      vecs++;
      if (moveStart !== 1'b0 || state !== 3'd0) begin
        errs++; $display("FAIL pause_block i=%0d: got start %b state %0d want 0 0", i, moveStart, state);
      end
    end
    pause = 1'b0; cyc(); tick = 1'b0;
    vecs++;
    if (moveStart !== 1'b1) begin errs++; $display("FAIL pause_release: got start %b want 1", moveStart); end
    pause = 1'b1;
    cnt = 0;
    while (state !== 3'd0 && cnt < 20) begin cyc(); cnt++; end
    vecs++;
    if (cnt != 8) begin errs++; $display("FAIL pause_inflight: got %0d want 8", cnt); end
    pause = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 99) != 0);
      pause = ($urandom_range(0, 99) < 10);
      tick  = ($urandom_range(0, 99) < 15);
      set_dones($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35);
      cyc();
      vecs++;
      if (outs !== mOuts()) begin
        errs++; $display("FAIL random i=%0d: got %h want %h", i, outs, mOuts());
      end
      if ($urandom_range(0, 199) == 0) begin
        rstN = 1'b0;
        #1;
        vecs++;
        if (outs !== 13'd0) begin errs++; $display("FAIL random_async_reset i=%0d: got %h want 0", i, outs); end
        rstN = 1'b1;
        model_clear();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal_frame();
    test_phase_wrap();
    test_abort();
    test_overrun();
    test_timeout();
    test_pause();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
